// File: rtl/serial_frame_decoder.sv
// Bit-serial frame decoder: finds a sync word, then assembles a fixed number of data
// words per frame with optional even parity. All outputs are registered.
module serial_frame_decoder #(
    parameter int                    DATA_WIDTH      = 8,
    parameter int                    WORDS_PER_FRAME = 4,
    parameter int                    SYNC_WIDTH      = 8,
    parameter logic [SYNC_WIDTH-1:0] SYNC_WORD       = 8'hA5,
    parameter int                    MSB_FIRST       = 1,
    parameter int                    PARITY_EN       = 1,
    localparam int IDX_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1
) (
    input  logic                  serial_clock,
    input  logic                  reset,
    input  logic                  serial_data,
    input  logic                  bit_strobe,
    output logic [DATA_WIDTH-1:0] word_data,
    output logic                  word_valid,
    output logic [IDX_W-1:0]      word_index,
    output logic                  frame_done,
    output logic                  frame_error,
    output logic                  locked
);
    localparam int FILL_W = $clog2(SYNC_WIDTH + 1);
    localparam int BIT_W  = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {HUNT, DATA, PARITY} state_t;

    state_t                r_state, w_state_next;
    logic [SYNC_WIDTH-1:0] r_window, w_window_next;
    logic [FILL_W-1:0]     r_fill, w_fill_next;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
    logic [BIT_W-1:0]      r_bit_cnt, w_bit_cnt_next;
    logic [IDX_W-1:0]      r_word_cnt, w_word_cnt_next;
    logic [DATA_WIDTH-1:0] r_word_data, w_word_data_next;
    logic [IDX_W-1:0]      r_word_index, w_word_index_next;
    logic                  r_word_valid, w_word_valid_next;
    logic                  r_frame_done, w_frame_done_next;
    logic                  r_frame_error, w_frame_error_next;
    logic                  r_locked, w_locked_next;

    logic [SYNC_WIDTH-1:0] w_window_shift;
    logic [DATA_WIDTH-1:0] w_shift_in;
    logic                  w_complete;
    logic [DATA_WIDTH-1:0] w_done_word;

    assign w_window_shift = {r_window[SYNC_WIDTH-2:0], serial_data};

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shift_in = {r_shift[DATA_WIDTH-2:0], serial_data};
        end else begin : g_lsb_first
            assign w_shift_in = {serial_data, r_shift[DATA_WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge serial_clock) begin
        if (reset) begin
            r_state       <= HUNT;
            r_window      <= '0;
            r_fill        <= '0;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_word_cnt    <= '0;
            r_word_data   <= '0;
            r_word_index  <= '0;
            r_word_valid  <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_error <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_window      <= w_window_next;
            r_fill        <= w_fill_next;
            r_shift       <= w_shift_next;
            r_bit_cnt     <= w_bit_cnt_next;
            r_word_cnt    <= w_word_cnt_next;
            r_word_data   <= w_word_data_next;
            r_word_index  <= w_word_index_next;
            r_word_valid  <= w_word_valid_next;
            r_frame_done  <= w_frame_done_next;
            r_frame_error <= w_frame_error_next;
            r_locked      <= w_locked_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_window_next      = r_window;
        w_fill_next        = r_fill;
        w_shift_next       = r_shift;
        w_bit_cnt_next     = r_bit_cnt;
        w_word_cnt_next    = r_word_cnt;
        w_word_data_next   = r_word_data;
        w_word_index_next  = r_word_index;
        w_word_valid_next  = 1'b0;
        w_frame_done_next  = 1'b0;
        w_frame_error_next = 1'b0;
        w_locked_next      = r_locked;
        w_complete         = 1'b0;
        w_done_word        = r_shift;

        if (bit_strobe) begin
            unique case (r_state)
                HUNT: begin
                    w_window_next = w_window_shift;
                    if (r_fill != FILL_W'(SYNC_WIDTH))
                        w_fill_next = r_fill + 1'b1;
                    // The fill guard stops the cleared window from matching before enough real bits arrive
                    if ((r_fill >= FILL_W'(SYNC_WIDTH - 1)) && (w_window_shift == SYNC_WORD)) begin
                        w_state_next    = DATA;
                        w_bit_cnt_next  = '0;
                        w_word_cnt_next = '0;
                        w_locked_next   = 1'b1;
                    end
                end
                DATA: begin
                    w_shift_next = w_shift_in;
                    if (r_bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
                        w_bit_cnt_next = '0;
                        if (PARITY_EN != 0) begin
                            w_state_next = PARITY;
                        end else begin
                            w_complete  = 1'b1;
                            w_done_word = w_shift_in;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (serial_data == ^r_shift) begin
                        w_complete  = 1'b1;
                        w_done_word = r_shift;
                    end else begin
                        w_frame_error_next = 1'b1;
                        w_state_next       = HUNT;
                        w_locked_next      = 1'b0;
                        w_window_next      = '0;
                        w_fill_next        = '0;
                    end
                end
                default: w_state_next = HUNT;
            endcase
        end

        if (w_complete) begin
            w_word_data_next  = w_done_word;
            w_word_index_next = r_word_cnt;
            w_word_valid_next = 1'b1;
            if (r_word_cnt == IDX_W'(WORDS_PER_FRAME - 1)) begin
                w_frame_done_next = 1'b1;
                w_state_next      = HUNT;
                w_locked_next     = 1'b0;
                w_window_next     = '0;
                w_fill_next       = '0;
            end else begin
                w_word_cnt_next = r_word_cnt + 1'b1;
                w_state_next    = DATA;
            end
        end
    end

    assign word_data   = r_word_data;
    assign word_valid  = r_word_valid;
    assign word_index  = r_word_index;
    assign frame_done  = r_frame_done;
    assign frame_error = r_frame_error;
    assign locked      = r_locked;

endmodule
